gray_tracker: RTL

GRAY_TRACKER -- requirements
Module: gray_tracker

---
 rtl/gray_pkg.sv | 12 +
 rtl/gray2bin.sv | 16 +
 rtl/gray_tracker.sv | 115 +++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-code position tracker.
package gray_pkg;

  localparam int unsigned WRAPCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_tracker.sv
// Tracks a Gray-coded counter, reporting steps, direction, wraps and illegal multi-bit jumps.
// Optional net wrap counter output enabled by defining GRAY_TRACKER_WRAPCNT_EN.
module gray_tracker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Valid,
  input  logic [WIDTH-1:0] Gray,
  input  logic             Resync,
  output logic [WIDTH-1:0] Binary,
  output logic             Step,
  output logic             Dir,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Fault,
`ifdef GRAY_TRACKER_WRAPCNT_EN
  output logic             Locked,
  output logic [WRAPCNT_W-1:0] WrapCnt
`else
  output logic             Locked
`endif
);

  state_t           state;
  logic [WIDTH-1:0] ref_gray;
  logic [WIDTH-1:0] conv_bin;
  logic [WIDTH-1:0] diff;
  logic             single_bit;
  logic             going_up;
  logic             wrap_up;
  logic             wrap_down;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (Gray),
    .bin  (conv_bin)
  );

  // Exactly one bit changed versus the reference: nonzero and a power of two.
  always_comb begin
    diff       = Gray ^ ref_gray;
    single_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
    going_up   = (conv_bin == WIDTH'(Binary + WIDTH'(1)));
    wrap_up    = going_up && (Binary == '1);
    wrap_down  = !going_up && (Binary == '0);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      ref_gray  <= '0;
      Binary    <= '0;
      Step      <= 1'b0;
      Dir       <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Fault     <= 1'b0;
      Locked    <= 1'b0;
`ifdef GRAY_TRACKER_WRAPCNT_EN
      WrapCnt   <= '0;
`endif
    end else begin
      Step <= 1'b0;
      if (Resync) begin
        // Drop the reference; position and sticky history survive.
        state  <= IDLE;
        Fault  <= 1'b0;
        Locked <= 1'b0;
      end else if (Valid) begin
        case (state)
          IDLE: begin
            Binary   <= conv_bin;
            ref_gray <= Gray;
            state    <= TRACK;
            Locked   <= 1'b1;
          end
          TRACK: begin
            if (single_bit) begin
              Binary   <= conv_bin;
              ref_gray <= Gray;
              Step     <= 1'b1;
              Dir      <= going_up;
              if (wrap_up) begin
                Overflow <= 1'b1;
`ifdef GRAY_TRACKER_WRAPCNT_EN
                WrapCnt  <= WrapCnt + WRAPCNT_W'(1);
`endif
              end
              if (wrap_down) begin
                Underflow <= 1'b1;
`ifdef GRAY_TRACKER_WRAPCNT_EN
                WrapCnt   <= WrapCnt - WRAPCNT_W'(1);
`endif
              end
            end else if (diff != '0) begin
              state  <= FAULT;
              Fault  <= 1'b1;
              Locked <= 1'b0;
            end
          end
          FAULT: begin
          end
          default: begin
            state  <= IDLE;
            Fault  <= 1'b0;
            Locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
